// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared shift-mode encoding for the pipelined barrel shifter and its stages.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_LSL = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result handshake bundle for barrel_shifter_pipe; slave is the shifter's view.
interface barrel_shifter_pipe_if #(
  parameter int N = 8
);
  localparam int S = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_amt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_carry;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );

endinterface

// File: rtl/barrel_shifter_pipe_stage.sv
// One log2 step of the barrel shifter: shift by 2^K when selected, else pass data and carry through.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic [N-1:0] i_data,
  input  shift_mode_e  i_mode,
  input  logic         i_sel,
  input  logic         i_carry,
  output logic [N-1:0] o_data,
  output logic         o_carry
);
  localparam int D = 1 << K;

  always_comb begin
    o_data  = i_data;
    o_carry = i_carry;
    if (i_sel) begin
      case (i_mode)
        SH_LSR: begin
          o_data  = {{D{1'b0}}, i_data[N-1:D]};
          o_carry = i_data[D-1];
        end
        SH_LSL: begin
          o_data  = {i_data[N-1-D:0], {D{1'b0}}};
          o_carry = i_data[N-D];
        end
        SH_ASR: begin
          o_data  = {{D{i_data[N-1]}}, i_data[N-1:D]};
          o_carry = i_data[D-1];
        end
        SH_ROR: begin
          o_data  = {i_data[D-1:0], i_data[N-1:D]};
          o_carry = i_data[D-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one shift_stage per register, elastic valid/ready with bubble collapse.
module barrel_shifter_pipe
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  barrel_shifter_pipe_if.slave  bus
);
  localparam int S = $clog2(N);

  logic [S-1:0] r_v;
  logic [N-1:0] r_data  [S];
  shift_mode_e  r_mode  [S];
  logic [S-1:0] r_amt   [S];
  logic         r_carry [S];

  logic [S-1:0] w_en;
  logic         w_in_ready;
  logic [S-1:0] w_src_v;
  logic [N-1:0] w_src_data  [S];
  shift_mode_e  w_src_mode  [S];
  logic [S-1:0] w_src_amt   [S];
  logic         w_src_carry [S];
  logic [N-1:0] w_sh_data   [S];
  logic         w_sh_carry  [S];

  // Stage k may load when it or any stage downstream of it has room.
  always_comb begin
    logic w_acc;
    w_en  = '0;
    w_acc = bus.out_ready;
    for (int unsigned k = S; k > 0; k--) begin
      w_acc      = w_acc | ~r_v[k-1];
      w_en[k-1]  = w_acc;
    end
    w_in_ready = w_en[0] & ~rst;
  end

  always_comb begin
    w_src_v[0]     = bus.in_valid & w_in_ready;
    w_src_data[0]  = bus.in_data;
    w_src_mode[0]  = shift_mode_e'(bus.in_mode);
    w_src_amt[0]   = bus.in_amt;
    w_src_carry[0] = 1'b0;
    for (int unsigned k = 1; k < S; k++) begin
      w_src_v[k]     = r_v[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_mode[k]  = r_mode[k-1];
      w_src_amt[k]   = r_amt[k-1];
      w_src_carry[k] = r_carry[k-1];
    end
  end

  for (genvar g = 0; g < S; g++) begin : g_stage
    shift_stage #(
      .N (N),
      .K (g)
    ) u_stage (
      .i_data  (w_src_data[g]),
      .i_mode  (w_src_mode[g]),
      .i_sel   (w_src_amt[g][g]),
      .i_carry (w_src_carry[g]),
      .o_data  (w_sh_data[g]),
      .o_carry (w_sh_carry[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int unsigned k = 0; k < S; k++) begin
        r_data[k]  <= '0;
        r_mode[k]  <= SH_LSR;
        r_amt[k]   <= '0;
        r_carry[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < S; k++) begin
        if (w_en[k]) begin
          r_v[k]     <= w_src_v[k];
          r_data[k]  <= w_sh_data[k];
          r_mode[k]  <= w_src_mode[k];
          r_amt[k]   <= w_src_amt[k];
          r_carry[k] <= w_sh_carry[k];
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = r_v[S-1];
    bus.out_data  = r_data[S-1];
    bus.out_carry = r_carry[S-1];
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (N=8): directed vectors, backpressure, random traffic, reset flush.
module tb_barrel_shifter_pipe;
  localparam int N = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.N(N)) bif ();

  barrel_shifter_pipe #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       carry;
    int         acc;
    bit         exact;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit   lat_exact = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: whole-word shift by amt using plain arithmetic.
  function automatic void ref_shift(input logic [7:0] d, input int a, input int m,
                                    output logic [7:0] r, output logic c);
    logic [15:0] dd;
    int          sd;
    case (m)
      0: r = d >> a;
      1: r = 8'(d << a);
      2: begin sd = int'($signed(d)); r = 8'(sd >>> a); end
      default: begin dd = {d, d}; dd = dd >> a; r = dd[7:0]; end
    endcase
    if (a == 0)      c = 1'b0;
    else if (m == 1) c = d[N-a];
    else             c = d[a-1];
  endfunction

  task automatic push_exp(input logic [7:0] ed, input logic ec);
    exp_t e;
    e.data  = ed;
    e.carry = ec;
    e.acc   = cyc;
    e.exact = lat_exact;
    q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                       input logic [7:0] ed, input logic ec);
    int n  = 0;
    bit ok = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    bif.in_amt   = a;
    bif.in_mode  = m;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bif.in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) push_exp(ed, ec);
    else    check("in_ready_timeout", {31'd0, bif.in_ready}, 32'd1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic issue_rand();
    logic [7:0] d, r;
    logic [2:0] a;
    logic [1:0] m;
    logic       c;
    d = 8'($urandom);
    a = 3'($urandom_range(0, 7));
    m = 2'($urandom_range(0, 3));
    ref_shift(d, int'(a), int'(m), r, c);
    issue(d, a, m, r, c);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    bif.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bif.out_ready = 1'b1;
        1:       bif.out_ready = ($urandom_range(0, 9) < 7);
        default: bif.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && bif.out_valid && bif.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", {31'd0, bif.out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", bif.out_data, e.data);
        check("out_carry", {31'd0, bif.out_carry}, {31'd0, e.carry});
        if (e.exact) check("latency", cyc - e.acc, S);
        else         check("latency_min", {31'd0, (cyc - e.acc) >= S}, 32'd1);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int         acc;
    logic [7:0] d, r;
    logic [2:0] a;
    logic [1:0] m;
    logic       c;

    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    bif.in_amt   = '0;
    bif.in_mode  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    check("rst_out_data", bif.out_data, 32'd0);
    check("rst_out_carry", {31'd0, bif.out_carry}, 32'd0);
    check("rst_in_ready", {31'd0, bif.in_ready}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, bif.in_ready}, 32'd1);
    @(posedge clk); #1;

    lat_exact = 1'b1;
    issue(8'h96, 3'd3, 2'd0, 8'h12, 1'b1);
    issue(8'h96, 3'd2, 2'd1, 8'h58, 1'b0);
    issue(8'h96, 3'd4, 2'd2, 8'hF9, 1'b0);
    issue(8'h96, 3'd3, 2'd3, 8'hD2, 1'b1);
    for (int i = 0; i < 4; i++) issue(8'h96, 3'd0, 2'(i), 8'h96, 1'b0);
    for (int i = 0; i < 8; i++) issue_rand();
    wait_drain();
    lat_exact = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    acc = 0;
    d = 8'($urandom); a = 3'($urandom_range(0, 7)); m = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = d;
      bif.in_amt   = a;
      bif.in_mode  = m;
      @(negedge clk);
      if (bif.in_ready) begin
        ref_shift(d, int'(a), int'(m), r, c);
        push_exp(r, c);
        acc++;
        d = 8'($urandom); a = 3'($urandom_range(0, 7)); m = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    check("bp_accepted", acc, 3);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, bif.in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, bif.out_valid}, 32'd1);
      if (q.size() > 0) begin
        check("bp_out_data_held", bif.out_data, q[0].data);
        check("bp_out_carry_held", {31'd0, bif.out_carry}, {31'd0, q[0].carry});
      end
    end
    rdy_mode = 0;
    repeat (3) begin
      @(negedge clk);
      check("burst_out_valid", {31'd0, bif.out_valid}, 32'd1);
    end
    @(negedge clk);
    check("burst_done_out_valid", {31'd0, bif.out_valid}, 32'd0);
    check("burst_queue_empty", q.size(), 0);
    @(posedge clk); #1;

    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      issue_rand();
    end
    rdy_mode = 0;
    wait_drain();
    @(posedge clk); #1;

    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    issue_rand();
    issue_rand();
    @(posedge clk); #3;
    check("pre_reset_out_valid", {31'd0, bif.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    check("async_rst_out_data", bif.out_data, 32'd0);
    check("async_rst_out_carry", {31'd0, bif.out_carry}, 32'd0);
    check("async_rst_in_ready", {31'd0, bif.in_ready}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("in_ready_after_flush", {31'd0, bif.in_ready}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("flushed_no_output", {31'd0, bif.out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
